// File: rtl/can_crc_pkg.sv
// Shared types and constants for the framed CAN CRC engine.
package can_crc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    TX_CRC = 2'd2,
    RX_CRC = 2'd3
  } crc_state_t;

  typedef enum logic {
    CRC_GEN = 1'b0,
    CRC_CHK = 1'b1
  } crc_mode_t;

  localparam logic [14:0] CAN_CRC15_POLY = 15'h4599;

endpackage

// File: rtl/can_crc_lfsr.sv
// Serial CRC register: one message bit per enabled cycle, MSB-first, no reflection.
module can_crc_lfsr #(
  parameter int                WIDTH = 15,
  parameter logic [WIDTH-1:0]  POLY  = 15'h4599,
  parameter logic [WIDTH-1:0]  INIT  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_init,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] crc,
  output logic [WIDTH-1:0] crc_next
);

  logic [WIDTH-1:0] crc_q;
  logic             fb;

  assign fb       = bit_in ^ crc_q[WIDTH-1];
  assign crc_next = {crc_q[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
  assign crc      = crc_q;

  always_ff @(posedge clk) begin
    if (rst || load_init) begin
      crc_q <= INIT;
    end else if (shift_en) begin
      crc_q <= crc_next;
    end
  end

endmodule

// File: rtl/can_crc_engine.sv
// Frame-level CRC engine: accumulates data bits, then either serialises the CRC
// under ready/valid or absorbs a received CRC field and reports pass/fail.
module can_crc_engine
  import can_crc_pkg::*;
#(
  parameter int                WIDTH = 15,
  parameter logic [WIDTH-1:0]  POLY  = CAN_CRC15_POLY,
  parameter logic [WIDTH-1:0]  INIT  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             bit_last,
  input  logic             crc_ready,
  output logic             crc_bit_out,
  output logic             crc_bit_valid,
  output logic [WIDTH-1:0] crc_out,
  output logic             busy,
  output logic             done,
  output logic             crc_ok
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  crc_state_t       state_q;
  crc_mode_t        mode_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] tx_idx;
  logic             done_q;
  logic             crc_ok_q;
  logic             bit_acc;
  logic             shift_en;
  logic [WIDTH-1:0] crc_q;
  logic [WIDTH-1:0] crc_next;

  // A bit arriving together with start belongs to no frame and is dropped.
  assign bit_acc  = bit_valid & ~start;
  assign shift_en = bit_acc & ((state_q == DATA) | (state_q == RX_CRC));

  can_crc_lfsr #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .INIT  (INIT)
  ) u_lfsr (
    .clk       (clk),
    .rst       (rst),
    .load_init (start),
    .shift_en  (shift_en),
    .bit_in    (bit_in),
    .crc       (crc_q),
    .crc_next  (crc_next)
  );

  assign tx_idx        = CNT_LAST - cnt_q;
  assign crc_bit_valid = (state_q == TX_CRC);
  assign crc_bit_out   = crc_bit_valid & crc_q[tx_idx];
  assign crc_out       = crc_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign crc_ok        = crc_ok_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mode_q   <= CRC_GEN;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      crc_ok_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        state_q  <= DATA;
        mode_q   <= crc_mode_t'(mode);
        cnt_q    <= '0;
        crc_ok_q <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: ;
          DATA: begin
            if (bit_acc && bit_last) begin
              state_q <= (mode_q == CRC_CHK) ? RX_CRC : TX_CRC;
              cnt_q   <= '0;
            end
          end
          TX_CRC: begin
            if (crc_ready) begin
              if (cnt_q == CNT_LAST) begin
                state_q  <= IDLE;
                cnt_q    <= '0;
                done_q   <= 1'b1;
                crc_ok_q <= 1'b0;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
          end
          RX_CRC: begin
            // Data plus its own CRC leaves a zero remainder on a clean frame.
            if (bit_acc) begin
              if (cnt_q == CNT_LAST) begin
                state_q  <= IDLE;
                cnt_q    <= '0;
                done_q   <= 1'b1;
                crc_ok_q <= (crc_next == '0);
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_can_crc_engine.sv
// Scoreboard bench for can_crc_engine: directed frames, monitor checks TX bits and done/crc_ok.
module tb_can_crc_engine;

  logic        clk = 1'b0;
  logic        rst, start, mode, bit_in, bit_valid, bit_last, crc_ready;
  logic        crc_bit_out, crc_bit_valid, busy, done, crc_ok;
  logic [14:0] crc_out;

  int errors = 0;
  int checks = 0;
  int accepts = 0;
  bit exp_tx[$];
  bit exp_ok[$];
  bit have_held = 1'b0;
  bit held_bit = 1'b0;

  logic [7:0] msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

  can_crc_engine dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .mode          (mode),
    .bit_in        (bit_in),
    .bit_valid     (bit_valid),
    .bit_last      (bit_last),
    .crc_ready     (crc_ready),
    .crc_bit_out   (crc_bit_out),
    .crc_bit_valid (crc_bit_valid),
    .crc_out       (crc_out),
    .busy          (busy),
    .done          (done),
    .crc_ok        (crc_ok)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, ahead of the edge that accepts a bit.
  always @(negedge clk) begin
    if (rst) begin
      have_held = 1'b0;
    end else begin
      if (have_held && crc_bit_valid) chk("tx_hold", crc_bit_out, held_bit);
      have_held = 1'b0;
      if (crc_bit_valid && !crc_ready && !start) begin
        have_held = 1'b1;
        held_bit  = crc_bit_out;
      end
      if (crc_bit_valid && crc_ready && !start) begin
        accepts++;
        if (exp_tx.size() == 0) chk("tx_unexpected", 1, 0);
        else chk("tx_bit", crc_bit_out, exp_tx.pop_front());
      end
      if (done) begin
        chk("done_busy", busy, 0);
        if (exp_ok.size() == 0) chk("done_unexpected", 1, 0);
        else chk("crc_ok", crc_ok, exp_ok.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic m);
    start = 1'b1;
    mode  = m;
    tick();
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b, input logic last);
    bit_valid = 1'b1;
    bit_in    = b;
    bit_last  = last;
    tick();
    bit_valid = 1'b0;
    bit_last  = 1'b0;
  endtask

  task automatic push_tx(input logic [14:0] v);
    for (int i = 14; i >= 0; i--) exp_tx.push_back(v[i]);
  endtask

  task automatic send_msg(input logic last_flag);
    for (int b = 0; b < 9; b++)
      for (int i = 7; i >= 0; i--)
        send_bit(msg[b][i], last_flag && (b == 8) && (i == 0));
  endtask

  task automatic run_tx(input bit toggle, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      crc_ready = toggle ? ~crc_ready : 1'b1;
      tick();
      n++;
    end
    crc_ready = 1'b1;
    if (busy) chk("tx_timeout", 1, 0);
  endtask

  initial begin
    logic [14:0] rx_crc;
    int acc0;
    rst = 1'b1; start = 1'b0; mode = 1'b0; bit_in = 1'b1;
    bit_valid = 1'b1; bit_last = 1'b0; crc_ready = 1'b1;

    // Reset, with bit_valid pulses that must be ignored
    tick(); tick();
    chk("rst_crc_out", crc_out, 15'h0000);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bit_valid", crc_bit_valid, 0);
    chk("rst_bit_out", crc_bit_out, 0);
    chk("rst_crc_ok", crc_ok, 0);
    rst = 1'b0;
    tick();
    bit_valid = 1'b0;
    chk("idle_ignores_bits", crc_out, 15'h0000);
    chk("idle_busy", busy, 0);

    // Short generate frame "1,0"
    do_start(1'b0);
    chk("start_busy", busy, 1);
    send_bit(1'b1, 1'b0);
    chk("gen_bit1", crc_out, 15'h4599);
    push_tx(15'h4EAB);
    exp_ok.push_back(1'b0);
    send_bit(1'b0, 1'b1);
    chk("gen_bit0_last", crc_out, 15'h4EAB);
    chk("tx_entry_valid", crc_bit_valid, 1);
    run_tx(1'b0, 40);
    chk("tx_frozen", crc_out, 15'h4EAB);

    // Standard vector with backpressure during TX_CRC
    do_start(1'b0);
    send_msg(1'b1);
    chk("std_vector", crc_out, 15'h059E);
    push_tx(15'h059E);
    exp_ok.push_back(1'b0);
    acc0 = accepts;
    run_tx(1'b1, 100);
    tick();
    chk("bp_accepts", accepts - acc0, 15);

    // Check mode, clean frame
    do_start(1'b1);
    send_msg(1'b1);
    exp_ok.push_back(1'b1);
    rx_crc = 15'h059E;
    for (int i = 14; i >= 0; i--) send_bit(rx_crc[i], 1'b0);
    chk("rx_idle", busy, 0);
    chk("rx_ok_level", crc_ok, 1);
    chk("rx_remainder", crc_out, 15'h0000);
    tick();

    // Check mode, CRC bit 7 corrupted
    do_start(1'b1);
    chk("start_clears_ok", crc_ok, 0);
    send_msg(1'b1);
    exp_ok.push_back(1'b0);
    rx_crc = 15'h059E ^ 15'h0080;
    for (int i = 14; i >= 0; i--) send_bit(rx_crc[i], 1'b0);
    chk("rx_bad_ok_level", crc_ok, 0);
    tick();

    // Abort after 10 data bits; bit_valid alongside the restart is dropped
    do_start(1'b0);
    for (int i = 0; i < 10; i++) send_bit(i[0], 1'b0);
    start = 1'b1; mode = 1'b0; bit_valid = 1'b1; bit_in = 1'b1;
    tick();
    start = 1'b0; bit_valid = 1'b0;
    chk("abort_crc_out", crc_out, 15'h0000);
    chk("abort_busy", busy, 1);
    chk("abort_no_done", done, 0);
    send_bit(1'b1, 1'b0);
    push_tx(15'h4EAB);
    exp_ok.push_back(1'b0);
    send_bit(1'b0, 1'b1);
    chk("abort_refrm", crc_out, 15'h4EAB);
    run_tx(1'b0, 40);
    tick();

    // Reset in the middle of TX_CRC
    do_start(1'b0);
    send_bit(1'b1, 1'b0);
    crc_ready = 1'b0;
    send_bit(1'b0, 1'b1);
    chk("mid_tx_valid", crc_bit_valid, 1);
    chk("mid_tx_msb", crc_bit_out, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    crc_ready = 1'b1;
    chk("rst_tx_busy", busy, 0);
    chk("rst_tx_valid", crc_bit_valid, 0);
    chk("rst_tx_crc", crc_out, 15'h0000);
    chk("rst_tx_done", done, 0);
    tick(); tick();

    chk("tx_queue_empty", exp_tx.size(), 0);
    chk("done_queue_empty", exp_ok.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
